coherence_bus: RTL and testbench
================================

COHERENCE_BUS -- requirements
Module: coherence_bus

Interface
REQ-001 Parameter MEM_LAT, default 3, memory response latency in cycles (legal 1..15).
REQ-002 Parameter MEM_INIT, default 16'h0000, memory word value after reset.
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  4  per-cache request pending; cache i drives bit i.
REQ-006 req_msg  input  88  four 22-bit messages; cache i owns bits [22i+21:22i]; [21:16] situation, [15:0] data.
REQ-007 req_grant  output  4  one-hot, one-cycle pulse; message of that cache accepted this cycle.
REQ-008 cdb  output  22  snoop broadcast message to all caches.
REQ-009 cdb_valid  output  1  cdb carries a valid broadcast this cycle.
REQ-010 cdb_src  output  2  index of the cache that originated the broadcast.
REQ-011 reply  output  22  memory data reply message.
REQ-012 reply_valid  output  1  reply valid this cycle.
REQ-013 reply_dst  output  2  index of the cache the reply is addressed to.
REQ-014 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-015 Situation codes: write miss 6'b000000, read miss 6'b000001, write-back 6'b000010, invalidate 6'b000100, data reply 6'b001000.
REQ-016 FSM states: IDLE, BCAST, MEM_WAIT, REPLY.
REQ-017 Arbitration occurs only in IDLE; with any req_valid set, exactly one grant issues and message plus index are latched; FSM -> BCAST.
REQ-018 Requests with situation write-back win over all others; among equal class, round-robin starting at (last granted index + 1) mod 4.
REQ-019 A cache holds req_valid and req_msg stable until its grant; the block samples req_msg only in the grant cycle.
REQ-020 BCAST lasts exactly one cycle: cdb_valid=1, cdb=latched message, cdb_src=latched index.
REQ-021 After BCAST: invalidate -> IDLE; write-back -> memory word <= data field, IDLE; read or write miss -> MEM_WAIT.
REQ-022 MEM_WAIT lasts exactly MEM_LAT cycles (down-counter loaded in BCAST), then REPLY.
REQ-023 REPLY lasts one cycle: reply_valid=1, reply={6'b001000, memory word}, reply_dst=latched index; then IDLE.
REQ-024 Latency from grant in cycle T: cdb_valid in T+1; reply_valid in T+2+MEM_LAT.
REQ-025 Next grant earliest T+2 for invalidate/write-back, T+3+MEM_LAT for misses; no grant while busy.
REQ-026 Any other situation code (including CPU-side 1xxxxx): granted, discarded, no broadcast, FSM -> IDLE after one cycle.
REQ-027 cdb, cdb_src, reply, reply_dst drive 0 whenever their valid is 0.
REQ-028 Write-back followed by a miss: reply carries the written-back data.

Reset
REQ-029 On reset_n low: FSM IDLE, all outputs 0, memory word = MEM_INIT, round-robin pointer so cache 0 has highest priority, counter 0.
REQ-030 Reset mid-operation aborts the transaction; no cdb_valid or reply_valid is produced for it after release.

Structure
REQ-031 Package coherence_pkg holds situation-code constants, the FSM state enum, MSG_W=22, N_CACHES=4.
REQ-032 One sub-module, rr_arbiter (4-way, priority-class input, pointer update on grant).

Verification
REQ-033 Cache 2 read miss alone, MEM_LAT=3 -> grant[2] in T, cdb_valid in T+1 with cdb_src=2, reply {001000,16'h0000} to 2 in T+5.
REQ-034 Caches 0,1,3 request misses simultaneously -> grants in order 0,1,3, each after the prior reply.
REQ-035 Cache 1 write miss and cache 3 write-back (data 16'hBEEF) together -> cache 3 granted first; cache 1 reply carries 16'hBEEF.
REQ-036 Invalidate from cache 0 -> single cdb_valid cycle, no reply, busy low at T+2.
REQ-037 Opcode 6'b100011 from cache 1 -> grant, no cdb_valid; reset asserted during MEM_WAIT -> no reply, all outputs 0.

Source files
------------

// File: rtl/coherence_pkg.sv
// Shared constants and types for the snooping coherence bus: message layout,
// situation codes and the bus controller states.
package coherence_pkg;

  localparam int MSG_W    = 22;
  localparam int N_CACHES = 4;
  localparam int DATA_W   = 16;
  localparam int SIT_W    = MSG_W - DATA_W;

  localparam logic [SIT_W-1:0] SIT_WRITE_MISS = 6'b000000;
  localparam logic [SIT_W-1:0] SIT_READ_MISS  = 6'b000001;
  localparam logic [SIT_W-1:0] SIT_WRITE_BACK = 6'b000010;
  localparam logic [SIT_W-1:0] SIT_INVALIDATE = 6'b000100;
  localparam logic [SIT_W-1:0] SIT_DATA_REPLY = 6'b001000;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_BCAST    = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_REPLY    = 2'd3
  } state_e;

  // Only these codes are snooped by the other caches; anything else is dropped.
  function automatic logic is_bcast_op(input logic [SIT_W-1:0] sit);
    return (sit == SIT_WRITE_MISS) || (sit == SIT_READ_MISS) ||
           (sit == SIT_WRITE_BACK) || (sit == SIT_INVALIDATE);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Four-way round-robin arbiter with a high-priority class; the pointer moves
// one past the winner whenever a grant issues.
module rr_arbiter
  import coherence_pkg::*;
(
  input  logic                clock,
  input  logic                reset_n,
  input  logic [N_CACHES-1:0] req_i,
  input  logic [N_CACHES-1:0] cls_i,
  output logic [N_CACHES-1:0] gnt_o,
  output logic [1:0]          idx_o
);

  logic [1:0]          ptr_q;
  logic [N_CACHES-1:0] cand;
  logic [1:0]          k;
  logic                found;

  always_comb begin
    cand  = (|(req_i & cls_i)) ? (req_i & cls_i) : req_i;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    k     = '0;
    for (int i = 0; i < N_CACHES; i++) begin
      k = ptr_q + 2'(i);
      if (!found && cand[k]) begin
        found    = 1'b1;
        gnt_o[k] = 1'b1;
        idx_o    = k;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else if (|gnt_o) begin
      ptr_q <= idx_o + 2'd1;
    end
  end

endmodule

// File: rtl/coherence_bus.sv
// Snooping bus controller: arbitrates cache requests, broadcasts the winner on
// the cdb and, for misses, returns the single memory word after MEM_LAT cycles.
module coherence_bus
  import coherence_pkg::*;
#(
  parameter int          MEM_LAT  = 3,
  parameter logic [15:0] MEM_INIT = 16'h0000
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [N_CACHES-1:0]       req_valid,
  input  logic [N_CACHES*MSG_W-1:0] req_msg,
  output logic [N_CACHES-1:0]       req_grant,
  output logic [MSG_W-1:0]          cdb,
  output logic                      cdb_valid,
  output logic [1:0]                cdb_src,
  output logic [MSG_W-1:0]          reply,
  output logic                      reply_valid,
  output logic [1:0]                reply_dst,
  output logic                      busy
);

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]   mem_q, mem_d;
  logic [MSG_W-1:0]    msg_q, sel_msg;
  logic [1:0]          src_q, gnt_idx;
  logic [N_CACHES-1:0] arb_req, wb_cls, gnt;
  logic [SIT_W-1:0]    sit_q;
  logic                idle;

  assign idle    = (state_q == ST_IDLE);
  // Grants are suppressed while reset is held so every output reads 0.
  assign arb_req = (idle && reset_n) ? req_valid : '0;
  assign sit_q   = msg_q[MSG_W-1:DATA_W];

  always_comb begin
    wb_cls  = '0;
    sel_msg = '0;
    for (int i = 0; i < N_CACHES; i++) begin
      wb_cls[i] = (req_msg[i*MSG_W+DATA_W +: SIT_W] == SIT_WRITE_BACK);
      if (gnt[i]) sel_msg = req_msg[i*MSG_W +: MSG_W];
    end
  end

  rr_arbiter u_arb (
    .clock   (clock),
    .reset_n (reset_n),
    .req_i   (arb_req),
    .cls_i   (wb_cls),
    .gnt_o   (gnt),
    .idx_o   (gnt_idx)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mem_d   = mem_q;
    case (state_q)
      ST_IDLE: begin
        if (|gnt) state_d = ST_BCAST;
      end
      ST_BCAST: begin
        state_d = ST_IDLE;
        case (sit_q)
          SIT_WRITE_BACK: mem_d = msg_q[DATA_W-1:0];
          SIT_READ_MISS, SIT_WRITE_MISS: begin
            state_d = ST_MEM_WAIT;
            cnt_d   = 4'(MEM_LAT);
          end
          default: ;
        endcase
      end
      ST_MEM_WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d = ST_REPLY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mem_q   <= MEM_INIT;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mem_q   <= mem_d;
    end
  end

  // Message and source are only meaningful while a transaction is open.
  always_ff @(posedge clock) begin
    if (|gnt) begin
      msg_q <= sel_msg;
      src_q <= gnt_idx;
    end
  end

  assign req_grant   = gnt;
  assign cdb_valid   = (state_q == ST_BCAST) && is_bcast_op(sit_q);
  assign cdb         = cdb_valid ? msg_q : '0;
  assign cdb_src     = cdb_valid ? src_q : '0;
  assign reply_valid = (state_q == ST_REPLY);
  assign reply       = reply_valid ? {SIT_DATA_REPLY, mem_q} : '0;
  assign reply_dst   = reply_valid ? src_q : '0;
  assign busy        = !idle;

endmodule

// File: tb/tb_coherence_bus.sv
// Directed bench for coherence_bus with MEM_LAT=3 and MEM_INIT=0.
module tb_coherence_bus;

  localparam logic [5:0] WM  = 6'b000000;
  localparam logic [5:0] RM  = 6'b000001;
  localparam logic [5:0] WB  = 6'b000010;
  localparam logic [5:0] INV = 6'b000100;
  localparam logic [5:0] DR  = 6'b001000;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [87:0] req_msg = '0;
  logic [3:0]  req_grant;
  logic [21:0] cdb;
  logic        cdb_valid;
  logic [1:0]  cdb_src;
  logic [21:0] reply;
  logic        reply_valid;
  logic [1:0]  reply_dst;
  logic        busy;

  int checks = 0;
  int errors = 0;

  coherence_bus #(.MEM_LAT(3), .MEM_INIT(16'h0000)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_msg     (req_msg),
    .req_grant   (req_grant),
    .cdb         (cdb),
    .cdb_valid   (cdb_valid),
    .cdb_src     (cdb_src),
    .reply       (reply),
    .reply_valid (reply_valid),
    .reply_dst   (reply_dst),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_msg(input int i, input logic [5:0] s, input logic [15:0] d);
    req_msg[i*22 +: 22] = {s, d};
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    req_valid = '0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    set_msg(0, RM, 16'h1111); set_msg(1, WB, 16'h2222);
    set_msg(2, INV, 16'h3333); set_msg(3, WM, 16'h4444);
    req_valid = 4'hF;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checks++; if (req_grant !== 4'b0000) begin errors++; $display("FAIL rst_grant: got %b want 0000", req_grant); end
    checks++; if ({busy, cdb_valid, reply_valid} !== 3'b000) begin errors++; $display("FAIL rst_flags: got %b want 000", {busy, cdb_valid, reply_valid}); end
    checks++; if ({cdb, cdb_src, reply, reply_dst} !== 48'h0) begin errors++; $display("FAIL rst_data: got %h want 0", {cdb, cdb_src, reply, reply_dst}); end
    req_valid = '0;
    @(posedge clock); #1 reset_n = 1'b1;
    @(negedge clock);
    checks++; if ({busy, req_grant} !== 5'b0) begin errors++; $display("FAIL rst_release: got %b want 00000", {busy, req_grant}); end
  endtask

  task automatic test_read_miss();
    @(posedge clock); #1;
    set_msg(2, RM, 16'h1234);
    req_valid = 4'b0100;
    @(negedge clock);
    checks++; if (req_grant !== 4'b0100) begin errors++; $display("FAIL rm_grant: got %b want 0100", req_grant); end
    @(posedge clock); #1 req_valid = '0;
    @(negedge clock);
    checks++; if ({cdb_valid, cdb_src, cdb} !== {1'b1, 2'd2, RM, 16'h1234}) begin errors++; $display("FAIL rm_cdb: got %b/%0d/%h want 1/2/%h", cdb_valid, cdb_src, cdb, {RM, 16'h1234}); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rm_busy: got %b want 1", busy); end
    for (int n = 2; n <= 4; n++) begin
      @(negedge clock);
      checks++; if ({reply_valid, cdb_valid} !== 2'b00) begin errors++; $display("FAIL rm_wait T+%0d: got %b want 00", n, {reply_valid, cdb_valid}); end
    end
    @(negedge clock);
    checks++; if ({reply_valid, reply_dst, reply} !== {1'b1, 2'd2, DR, 16'h0000}) begin errors++; $display("FAIL rm_reply: got %b/%0d/%h want 1/2/%h", reply_valid, reply_dst, reply, {DR, 16'h0000}); end
    @(negedge clock);
    checks++; if ({busy, reply_valid, reply} !== 24'h0) begin errors++; $display("FAIL rm_done: got %b/%b/%h want 0/0/0", busy, reply_valid, reply); end
  endtask

  task automatic test_three_misses();
    logic [3:0] exp_g [3] = '{4'b0001, 4'b0010, 4'b1000};
    int         exp_d [3] = '{0, 1, 3};
    logic [3:0] gi [$];
    int         gc [$];
    int         rd [$];
    int         rc [$];
    logic [3:0] clr;
    do_reset();
    set_msg(0, RM, 16'hA000); set_msg(1, RM, 16'hA001); set_msg(3, RM, 16'hA003);
    req_valid = 4'b1011;
    for (int n = 0; n < 40 && rd.size() < 3; n++) begin
      @(negedge clock);
      clr = req_grant;
      if (req_grant != 4'b0) begin gi.push_back(req_grant); gc.push_back(n); end
      if (reply_valid) begin rd.push_back(int'(reply_dst)); rc.push_back(n); end
      @(posedge clock); #1 req_valid = req_valid & ~clr;
    end
    checks++; if (gi.size() != 3 || rd.size() != 3) begin errors++; $display("FAIL mm_count: got %0d grants %0d replies want 3 3", gi.size(), rd.size()); end
    for (int k = 0; k < 3; k++) begin
      if (k < gi.size() && k < rd.size()) begin
        checks++; if (gi[k] !== exp_g[k]) begin errors++; $display("FAIL mm_grant%0d: got %b want %b", k, gi[k], exp_g[k]); end
        checks++; if (gc[k] - gc[0] != 6 * k) begin errors++; $display("FAIL mm_spacing%0d: got %0d want %0d", k, gc[k] - gc[0], 6 * k); end
        checks++; if (rd[k] != exp_d[k]) begin errors++; $display("FAIL mm_dst%0d: got %0d want %0d", k, rd[k], exp_d[k]); end
        checks++; if (rc[k] - gc[k] != 5) begin errors++; $display("FAIL mm_latency%0d: got %0d want 5", k, rc[k] - gc[k]); end
      end
    end
  endtask

  task automatic test_wb_priority();
    @(posedge clock); #1;
    set_msg(1, WM, 16'h5A5A); set_msg(3, WB, 16'hBEEF);
    req_valid = 4'b1010;
    @(negedge clock);
    checks++; if (req_grant !== 4'b1000) begin errors++; $display("FAIL wb_grant: got %b want 1000", req_grant); end
    @(posedge clock); #1 req_valid = 4'b0010;
    @(negedge clock);
    checks++; if ({cdb_valid, cdb_src, cdb} !== {1'b1, 2'd3, WB, 16'hBEEF}) begin errors++; $display("FAIL wb_cdb: got %b/%0d/%h want 1/3/%h", cdb_valid, cdb_src, cdb, {WB, 16'hBEEF}); end
    checks++; if (req_grant !== 4'b0000) begin errors++; $display("FAIL wb_nogrant_busy: got %b want 0000", req_grant); end
    @(negedge clock);
    checks++; if ({busy, req_grant} !== 5'b0_0010) begin errors++; $display("FAIL wb_second_grant: got %b want 00010", {busy, req_grant}); end
    @(posedge clock); #1 req_valid = '0;
    @(negedge clock);
    checks++; if ({cdb_valid, cdb_src, cdb} !== {1'b1, 2'd1, WM, 16'h5A5A}) begin errors++; $display("FAIL wm_cdb: got %b/%0d/%h want 1/1/%h", cdb_valid, cdb_src, cdb, {WM, 16'h5A5A}); end
    repeat (4) @(negedge clock);
    checks++; if ({reply_valid, reply_dst, reply} !== {1'b1, 2'd1, DR, 16'hBEEF}) begin errors++; $display("FAIL wm_reply: got %b/%0d/%h want 1/1/%h", reply_valid, reply_dst, reply, {DR, 16'hBEEF}); end
    @(negedge clock);
  endtask

  task automatic test_invalidate();
    int nv;
    @(posedge clock); #1;
    set_msg(0, INV, 16'h00C3);
    req_valid = 4'b0001;
    @(negedge clock);
    checks++; if (req_grant !== 4'b0001) begin errors++; $display("FAIL inv_grant: got %b want 0001", req_grant); end
    @(posedge clock); #1 req_valid = '0;
    @(negedge clock);
    checks++; if ({cdb_valid, cdb_src, cdb} !== {1'b1, 2'd0, INV, 16'h00C3}) begin errors++; $display("FAIL inv_cdb: got %b/%0d/%h want 1/0/%h", cdb_valid, cdb_src, cdb, {INV, 16'h00C3}); end
    @(negedge clock);
    checks++; if ({busy, cdb_valid} !== 2'b00) begin errors++; $display("FAIL inv_idle: got %b want 00", {busy, cdb_valid}); end
    nv = 0;
    repeat (6) begin @(negedge clock); if (reply_valid || cdb_valid) nv++; end
    checks++; if (nv != 0) begin errors++; $display("FAIL inv_quiet: got %0d active cycles want 0", nv); end
  endtask

  task automatic test_bad_opcode();
    @(posedge clock); #1;
    set_msg(1, 6'b100011, 16'h7777);
    req_valid = 4'b0010;
    @(negedge clock);
    checks++; if (req_grant !== 4'b0010) begin errors++; $display("FAIL bad_grant: got %b want 0010", req_grant); end
    @(posedge clock); #1 req_valid = '0;
    @(negedge clock);
    checks++; if ({cdb_valid, cdb, cdb_src} !== 25'h0) begin errors++; $display("FAIL bad_cdb: got %b/%h/%0d want 0/0/0", cdb_valid, cdb, cdb_src); end
    @(negedge clock);
    checks++; if ({busy, reply_valid, cdb_valid} !== 3'b000) begin errors++; $display("FAIL bad_idle: got %b want 000", {busy, reply_valid, cdb_valid}); end
  endtask

  task automatic test_reset_mid();
    int nv;
    @(posedge clock); #1;
    set_msg(2, RM, 16'h9999);
    req_valid = 4'b0100;
    @(negedge clock);
    checks++; if (req_grant !== 4'b0100) begin errors++; $display("FAIL rmid_grant: got %b want 0100", req_grant); end
    @(posedge clock); #1 req_valid = '0;
    @(negedge clock);
    @(negedge clock);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_busy: got %b want 1", busy); end
    reset_n = 1'b0;
    #1;
    checks++; if ({busy, cdb_valid, reply_valid, req_grant, cdb, cdb_src, reply, reply_dst} !== 55'h0) begin errors++; $display("FAIL rmid_outputs: got %b/%b/%b/%b want all 0", busy, cdb_valid, reply_valid, req_grant); end
    @(posedge clock); @(posedge clock); #1 reset_n = 1'b1;
    nv = 0;
    repeat (8) begin @(negedge clock); if (reply_valid || cdb_valid || busy) nv++; end
    checks++; if (nv != 0) begin errors++; $display("FAIL rmid_aborted: got %0d active cycles want 0", nv); end
    // Memory must be back at its initial value after the reset.
    @(posedge clock); #1;
    set_msg(0, RM, 16'h0001);
    req_valid = 4'b0001;
    @(negedge clock);
    checks++; if (req_grant !== 4'b0001) begin errors++; $display("FAIL rmid_regrant: got %b want 0001", req_grant); end
    @(posedge clock); #1 req_valid = '0;
    repeat (5) @(negedge clock);
    checks++; if ({reply_valid, reply_dst, reply} !== {1'b1, 2'd0, DR, 16'h0000}) begin errors++; $display("FAIL rmid_mem_init: got %b/%0d/%h want 1/0/%h", reply_valid, reply_dst, reply, {DR, 16'h0000}); end
  endtask

  initial begin
    test_reset();
    test_read_miss();
    test_three_misses();
    test_wb_priority();
    test_invalidate();
    test_bad_opcode();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
